// File: rtl/madd_issue.sv
// Operand sequencer in front of the MADD multiply-add unit: issues A/B then C one
// cycle later, captures Z after LAT cycles into a credit-controlled response FIFO.
module madd_issue #(
    parameter int W     = 32,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         REQ_VALID,
    output logic         REQ_READY,
    input  logic [W-1:0] REQ_A,
    input  logic [W-1:0] REQ_B,
    input  logic [W-1:0] REQ_C,
    input  logic         REQ_ACC,
    output logic         RSP_VALID,
    input  logic         RSP_READY,
    output logic [W-1:0] RSP_Z,
    output logic [W-1:0] M_A,
    output logic [W-1:0] M_B,
    output logic [W-1:0] M_C,
    output logic         M_ENAB,
    output logic         M_ENC,
    input  logic [W-1:0] M_Z
);

    localparam int TAGN = LAT + 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + TAGN + 1) + 1;

    logic [W-1:0]  m_a_q, m_b_q, m_c_q;
    logic          m_enab_q, m_enc_q;
    logic [W-1:0]  c_stage_q;
    logic          c_pend_q;
    logic [W-1:0]  acc_q;
    logic [TAGN-1:0] tag_q;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [CW-1:0] inflight;
    logic [CW-1:0] outstanding;
    logic          accept;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < TAGN; i++) begin
            inflight = inflight + CW'(tag_q[i]);
        end
    end

    // A result landing this edge is still counted in inflight, so ACC waits one more edge
    assign outstanding = inflight + fifo_cnt_q;
    assign REQ_READY   = (outstanding < CW'(DEPTH)) && !(REQ_ACC && (inflight != '0));
    assign accept      = REQ_VALID && REQ_READY;
    assign push        = tag_q[TAGN-1];
    assign RSP_VALID   = (fifo_cnt_q != '0);
    assign pop         = RSP_VALID && RSP_READY;
    assign RSP_Z       = mem_q[rd_ptr_q];

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_a_q      <= '0;
            m_b_q      <= '0;
            m_c_q      <= '0;
            m_enab_q   <= 1'b0;
            m_enc_q    <= 1'b0;
            c_stage_q  <= '0;
            c_pend_q   <= 1'b0;
            acc_q      <= '0;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            m_enab_q <= accept;
            c_pend_q <= accept;
            m_enc_q  <= c_pend_q;
            tag_q    <= {tag_q[TAGN-2:0], accept};
            if (accept) begin
                m_a_q     <= REQ_A;
                m_b_q     <= REQ_B;
                c_stage_q <= REQ_ACC ? acc_q : REQ_C;
            end
            if (c_pend_q) begin
                m_c_q <= c_stage_q;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= M_Z;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
                acc_q           <= M_Z;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assign M_A    = m_a_q;
    assign M_B    = m_b_q;
    assign M_C    = m_c_q;
    assign M_ENAB = m_enab_q;
    assign M_ENC  = m_enc_q;

    // Credits bound outstanding work to DEPTH, so the FIFO can never be pushed while full
    a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
        !(push && (fifo_cnt_q == CW'(DEPTH))));

endmodule

// File: tb/tb_madd_issue.sv
// Scoreboard bench for madd_issue: a behavioural MADD partner, a rule-based
// reference model and a negedge monitor that checks every cycle.
module tb_madd_issue;

    localparam int W     = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic         REQ_VALID;
    logic         REQ_READY;
    logic [W-1:0] REQ_A, REQ_B, REQ_C;
    logic         REQ_ACC;
    logic         RSP_VALID;
    logic         RSP_READY = 1'b0;
    logic [W-1:0] RSP_Z;
    logic [W-1:0] M_A, M_B, M_C;
    logic         M_ENAB, M_ENC;
    logic [W-1:0] M_Z;

    madd_issue #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_C(REQ_C), .REQ_ACC(REQ_ACC),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_Z(RSP_Z),
        .M_A(M_A), .M_B(M_B), .M_C(M_C),
        .M_ENAB(M_ENAB), .M_ENC(M_ENC), .M_Z(M_Z)
    );

    always #5 CLK = ~CLK;

    // MADD unit: captures A/B on ENAB, C on ENC, Z valid before the edge t+1+LAT (LAT=2)
    logic [W-1:0] ma, mb, mz;
    always @(posedge CLK) begin
        if (M_ENAB) begin
            ma <= M_A;
            mb <= M_B;
        end
        if (M_ENC) mz <= ma * mb + M_C;
    end
    assign M_Z = mz;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {int t; logic [W-1:0] c;} op_t;
    op_t          pend[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] acc_model = '0;
    int           accepted = 0;
    int           pops = 0;
    int           landed = 0;
    int           cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    bit   rdy_rand  = 1'b0;
    logic rdy_fixed = 1'b0;
    always @(posedge CLK) begin
        #1;
        RSP_READY = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // Monitor: checks state after edge cyc, then books the handshakes of edge cyc+1
    always @(negedge CLK) begin
        if (!RSTN) begin
            pend.delete();
            exp_q.delete();
            acc_model = '0;
            accepted  = 0;
            pops      = 0;
            landed    = 0;
        end else begin
            bit   exp_valid, exp_ready, exp_enc;
            logic [W-1:0] exp_c, cval, res;
            while (pend.size() > 0 && pend[0].t + 1 + LAT <= cyc) begin
                void'(pend.pop_front());
                landed++;
            end
            exp_valid = (landed - pops) > 0;
            chk("rsp_valid", 32'(RSP_VALID), 32'(exp_valid));
            if (exp_valid && exp_q.size() > 0) chk("rsp_z", RSP_Z, exp_q[0]);
            exp_ready = ((accepted - pops) < DEPTH) && !(REQ_ACC && pend.size() > 0);
            chk("req_ready", 32'(REQ_READY), 32'(exp_ready));
            chk("m_enab", 32'(M_ENAB), 32'(pend.size() > 0 && pend[$].t == cyc));
            exp_enc = 1'b0;
            exp_c   = '0;
            foreach (pend[i]) if (pend[i].t == cyc - 1) begin
                exp_enc = 1'b1;
                exp_c   = pend[i].c;
            end
            chk("m_enc", 32'(M_ENC), 32'(exp_enc));
            if (exp_enc) chk("m_c", M_C, exp_c);

            if (REQ_VALID && REQ_READY) begin
                cval      = REQ_ACC ? acc_model : REQ_C;
                res       = REQ_A * REQ_B + cval;
                acc_model = res;
                pend.push_back('{cyc + 1, cval});
                exp_q.push_back(res);
                accepted++;
            end
            if (RSP_VALID && RSP_READY && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                pops++;
            end
        end
    end

    // All stimulus tasks start and end at posedge+2
    task automatic set_rdy(input logic v);
        rdy_fixed = v;
        @(posedge CLK); #2;
    endtask

    task automatic send(input logic [W-1:0] a, b, c, input logic acc, output int waits);
        bit done = 1'b0;
        REQ_VALID = 1'b1; REQ_A = a; REQ_B = b; REQ_C = c; REQ_ACC = acc;
        waits = 0;
        while (!done && waits < 200) begin
            @(negedge CLK);
            if (REQ_READY) done = 1'b1;
            else waits++;
            @(posedge CLK); #2;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: request not accepted in %0d cycles", waits);
        end
        REQ_VALID = 1'b0; REQ_ACC = 1'b0;
    endtask

    task automatic present(input logic [W-1:0] a, b, c, output bit ok);
        REQ_VALID = 1'b1; REQ_A = a; REQ_B = b; REQ_C = c; REQ_ACC = 1'b0;
        @(negedge CLK);
        ok = REQ_READY;
        @(posedge CLK); #2;
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_rsp(input string nm, input logic [W-1:0] exp);
        bit done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge CLK);
            if (RSP_VALID && RSP_READY) begin
                chk(nm, RSP_Z, exp);
                done = 1'b1;
            end
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL %s: no response within 20 cycles, expected %h", nm, exp);
        end
        @(posedge CLK); #2;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_req_ready"}, 32'(REQ_READY), 32'd1);
        chk({nm, "_rsp_valid"}, 32'(RSP_VALID), 32'd0);
        chk({nm, "_rsp_z"}, RSP_Z, 32'd0);
        chk({nm, "_m_a"}, M_A, 32'd0);
        chk({nm, "_m_b"}, M_B, 32'd0);
        chk({nm, "_m_c"}, M_C, 32'd0);
        chk({nm, "_m_enab"}, 32'(M_ENAB), 32'd0);
        chk({nm, "_m_enc"}, 32'(M_ENC), 32'd0);
    endtask

    initial begin
        int w;
        int n_acc;
        bit ok;
        RSTN = 1'b0; REQ_VALID = 1'b0; REQ_ACC = 1'b0;
        REQ_A = '0; REQ_B = '0; REQ_C = '0;
        repeat (2) @(posedge CLK); #2;
        chk_reset_vals("por");
        RSTN = 1'b1;
        @(posedge CLK); #2;

        // Single op and signed/wrap cases
        set_rdy(1'b1);
        send(32'd3, 32'd5, 32'd7, 1'b0, w);
        wait_rsp("single", 32'h0000_0016);
        send(-32'sd4, 32'd6, 32'd10, 1'b0, w);
        wait_rsp("signed", 32'hFFFF_FFF2);
        send(32'h7FFF_FFFF, 32'd2, 32'd0, 1'b0, w);
        wait_rsp("wrap", 32'hFFFF_FFFE);

        // Back-pressure: only DEPTH of 6 back-to-back requests are taken
        set_rdy(1'b0);
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            present(W'(i + 1), 32'd10, W'(i), ok);
            if (ok) n_acc++;
        end
        chk("bp_accepted", 32'(n_acc), 32'd4);
        @(negedge CLK);
        chk("bp_ready_low", 32'(REQ_READY), 32'd0);
        repeat (4) @(posedge CLK); #2;
        set_rdy(1'b1);
        wait_rsp("bp0", 32'd10);
        wait_rsp("bp1", 32'd21);
        wait_rsp("bp2", 32'd32);
        wait_rsp("bp3", 32'd43);

        // Accumulate chain: dependent op stalls LAT+1 cycles
        set_rdy(1'b0);
        send(32'd2, 32'd3, 32'd1, 1'b0, w);
        send(32'd1, 32'd1, 32'd0, 1'b1, w);
        chk("acc_stall", 32'(w), 32'(LAT + 1));
        repeat (4) @(posedge CLK); #2;
        set_rdy(1'b1);
        wait_rsp("acc0", 32'd7);
        wait_rsp("acc1", 32'd8);

        // Reset with two ops in flight
        send(32'd5, 32'd5, 32'd5, 1'b0, w);
        send(32'd6, 32'd6, 32'd6, 1'b0, w);
        RSTN = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge CLK); #2;
        RSTN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("post_rst_quiet", 32'(RSP_VALID), 32'd0);
        end
        @(posedge CLK); #2;

        // Random soak
        rdy_rand = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] a, b, c;
            a = ($urandom_range(0, 3) == 0) ? W'($signed($urandom_range(0, 16)) - 8) : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? W'($signed($urandom_range(0, 16)) - 8) : W'($urandom);
            c = W'($urandom);
            send(a, b, c, ($urandom_range(0, 9) < 3), w);
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #0;
        end
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(posedge CLK);
        repeat (2) @(posedge CLK); #2;
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/madd_issue.md
# madd_issue

Operand sequencer that sits in front of the MADD multiply-add unit and acts as its initiator. It accepts multiply-add requests over a valid/ready port and drives the MADD operand/enable pins with the unit's two-phase protocol: A/B with ENAB, then C with ENC one cycle later. It captures Z after the fixed MADD latency, buffers results in a small response FIFO under credit-based back-pressure, and offers an accumulate mode that feeds the previous result back as C.

## Interface
- W, 32, operand/result width (two's complement)
- LAT, 2, cycles from the MADD edge that captures A/B to Z being valid
- DEPTH, 4, response FIFO depth; also the maximum number of outstanding operations
- CLK  in  1  single clock, all state on rising edge
- RSTN  in  1  reset, asynchronous assert, active-low
- REQ_VALID  in  1  request present
- REQ_READY  out  1  request accepted on an edge where VALID&&READY
- REQ_A, REQ_B, REQ_C  in  W each  signed operands
- REQ_ACC  in  1  use accumulator register instead of REQ_C
- RSP_VALID  out  1  response FIFO non-empty
- RSP_READY  in  1  consumer pops on an edge where VALID&&READY
- RSP_Z  out  W  head-of-FIFO result
- M_A, M_B, M_C  out  W each  registered operands to MADD
- M_ENAB, M_ENC  out  1 each  MADD operand enables
- M_Z  in  W  MADD result

## Operation
- Accept at edge t: at that edge, M_A/M_B load REQ_A/REQ_B and M_ENAB=1, so MADD captures at edge t+1. At edge t+1, M_C loads the selected C and M_ENC=1 (C follows A/B by one cycle).
- Selected C = ACC_R when REQ_ACC=1, else REQ_C. It is held in a stage register from edge t.
- Enables are high for exactly one cycle per operation. When idle, M_ENAB/M_ENC=0 and M_A/M_B/M_C hold their last values.
- In-flight tracking: tag shift register of length 2+LAT-1. At edge t+1+LAT, M_Z is pushed into the FIFO and written to ACC_R.
- Credits: outstanding = inflight + fifo_count. REQ_READY = (outstanding < DEPTH) && !(REQ_ACC && inflight != 0). REQ_READY is combinational from state and REQ_ACC. A pop in the current cycle does not free a credit until the next cycle.
- Accumulate hazard: an ACC request stalls until every earlier result has landed in ACC_R. A result landing at the same edge counts as still in flight.
- Arithmetic: result is the low W bits of A*B+C (MADD semantics), signed, wraps silently, no overflow flag.
- FIFO: push and pop on the same edge leaves occupancy unchanged; pop when empty is ignored. Push while full is impossible by construction, and an assertion checks this.
- Reset (RSTN low, any time): in-flight tags, FIFO, and ACC_R are cleared. Results from operations in progress are discarded, including any that complete after release.

## Timing
- Reset values: REQ_READY=1, RSP_VALID=0, RSP_Z=0, M_A=M_B=M_C=0, M_ENAB=M_ENC=0, ACC_R=0.
- Request-to-response latency: RSP_VALID rises after edge t+1+LAT, which is 3 cycles after acceptance for LAT=2.
- Throughput: one operation per cycle while credits remain and there is no ACC hazard.
- ACC issue: at the earliest edge after the prior result lands, i.e. a back-to-back dependent op stalls LAT+1 cycles.
- RSP_Z is stable while RSP_VALID=1 and RSP_READY=0.

## Test plan
- Single op, A=3, B=5, C=7, RSP_READY=1 -> M_ENAB pulse after edge 0, M_ENC pulse after edge 1, RSP_VALID=1 with RSP_Z=0x00000016 after edge 3, for one cycle.
- Signed and wrap: A=-4, B=6, C=10 -> 0xFFFFFFF2. A=0x7FFFFFFF, B=2, C=0 -> 0xFFFFFFFE.
- Back-pressure: RSP_READY=0, 6 back-to-back requests -> exactly 4 accepted, REQ_READY=0 afterwards. Raising RSP_READY drains 4 results in order, and REQ_READY returns one cycle after the first pop.
- Accumulate chain: op1 (2,3,C=1) then op2 (1,1,ACC=1) presented the next cycle -> REQ_READY low until op1 lands. Responses are 7 then 8, and M_C=7 during op2's ENC cycle.
- Reset mid-operation: 2 ops in flight, pull RSTN low for 1 cycle -> all outputs return to reset values immediately and no RSP_VALID appears within 10 cycles after release.
- Random soak: 1000 random ops with random REQ_ACC and random RSP_READY, checked against a scoreboard model -> zero mismatches and no FIFO overflow assertion.
